// File: rtl/gon_xbus_tx_if.sv
// GON X-bus transmitter port bundle: upstream beat input, column config/ready, bus outputs.
interface gon_xbus_tx_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned NUM_OF_COLS   = 14
);
  logic                                          in_valid;
  logic                                          in_ready;
  logic [COL_TAG_WIDTH-1:0]                      in_tag;
  logic [DATA_WIDTH-1:0]                         in_data;
  logic [NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0]     col_id;
  logic [0:NUM_OF_COLS-1]                        col_ready;
  logic [COL_TAG_WIDTH-1:0]                      col_tag;
  logic [DATA_WIDTH-1:0]                         data_out;
  logic                                          enable_out;
  logic [0:NUM_OF_COLS-1]                        col_mask;
  logic [15:0]                                   drop_count;

  // Transmitter side
  modport master (
    input  in_valid, in_tag, in_data, col_id, col_ready,
    output in_ready, col_tag, data_out, enable_out, col_mask, drop_count
  );

  // Environment side (upstream source, columns)
  modport slave (
    output in_valid, in_tag, in_data, col_id, col_ready,
    input  in_ready, col_tag, data_out, enable_out, col_mask, drop_count
  );
endinterface

// File: rtl/gon_xbus_tx.sv
// GON X-bus source transmitter: 2-entry input FIFO with bypass, one output stage
// held until every matching column has returned ready (multicast enable/ready).
module gon_xbus_tx #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned NUM_OF_COLS   = 14
) (
  input logic            clk,
  input logic            reset,
  gon_xbus_tx_if.master  bus
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t state, state_next;

  logic [COL_TAG_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic                     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]         count, count_next;

  logic                     fifo_empty;
  logic                     push, complete, stage_free;
  logic                     load, stage_load, drop, pop, bypass, fifo_write;
  logic [COL_TAG_WIDTH-1:0] src_tag;
  logic [DATA_WIDTH-1:0]    src_data;
  logic [0:NUM_OF_COLS-1]   src_mask;

  // Columns selected by a tag; all-ones tag reaches every column
  function automatic logic [0:NUM_OF_COLS-1] match_cols(
    input logic [COL_TAG_WIDTH-1:0]                  tag,
    input logic [NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0] ids
  );
    logic [0:NUM_OF_COLS-1] m;
    m = '0;
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      m[i] = (tag == ids[i]) || (tag == {COL_TAG_WIDTH{1'b1}});
    end
    return m;
  endfunction

  assign fifo_empty = (count == '0);
  assign push       = bus.in_valid & bus.in_ready;
  assign complete   = bus.enable_out & (&(~bus.col_mask | bus.col_ready));
  assign stage_free = (state == IDLE) | complete;
  assign src_tag    = fifo_empty ? bus.in_tag  : fifo_tag[rd_ptr];
  assign src_data   = fifo_empty ? bus.in_data : fifo_data[rd_ptr];
  assign src_mask   = match_cols(src_tag, bus.col_id);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a matched load keeps/enters SEND, completion with no matched load returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stage_load) state_next = SEND;
      SEND:    if (complete)   state_next = stage_load ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes: stage load/drop, FIFO pop vs. bypass, occupancy update
  always_comb begin
    load       = 1'b0;
    stage_load = 1'b0;
    drop       = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    fifo_write = 1'b0;
    load       = stage_free & (~fifo_empty | bus.in_valid);
    stage_load = load & (|src_mask);
    drop       = load & ~(|src_mask);
    pop        = load & ~fifo_empty;
    bypass     = load & fifo_empty;
    fifo_write = push & ~bypass;
    count_next = count;
    if (fifo_write && !pop)      count_next = CNT_W'(count + CNT_W'(1));
    else if (pop && !fifo_write) count_next = CNT_W'(count - CNT_W'(1));
  end

  // FIFO storage, no reset needed since count gates all reads
  always_ff @(posedge clk) begin
    if (fifo_write) begin
      fifo_tag[wr_ptr]  <= bus.in_tag;
      fifo_data[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy, output stage and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      count          <= '0;
      bus.in_ready   <= 1'b1;
      bus.enable_out <= 1'b0;
      bus.col_tag    <= '0;
      bus.data_out   <= '0;
      bus.col_mask   <= '0;
      bus.drop_count <= '0;
    end else begin
      if (fifo_write) wr_ptr <= ~wr_ptr;
      if (pop)        rd_ptr <= ~rd_ptr;
      count          <= count_next;
      bus.in_ready   <= (count_next != CNT_W'(FIFO_DEPTH));
      bus.enable_out <= (state_next == SEND);
      if (stage_load) begin
        bus.col_tag  <= src_tag;
        bus.data_out <= src_data;
        bus.col_mask <= src_mask;
      end
      if (drop && (bus.drop_count != 16'hFFFF)) begin
        bus.drop_count <= 16'(bus.drop_count + 16'd1);
      end
    end
  end

endmodule

// File: tb/tb_gon_xbus_tx.sv
// Directed self-checking bench for gon_xbus_tx.
module tb_gon_xbus_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 4;
  localparam int unsigned NC = 14;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  gon_xbus_tx_if #(.DATA_WIDTH(DW), .COL_TAG_WIDTH(TW), .NUM_OF_COLS(NC)) bus ();

  gon_xbus_tx #(.DATA_WIDTH(DW), .COL_TAG_WIDTH(TW), .NUM_OF_COLS(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ids_linear();
    for (int i = 0; i < NC; i++) bus.col_id[i] = TW'(i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_tag = '0; bus.in_data = '0;
    bus.col_ready = '0;
    ids_linear();
    tick(); tick();
    reset = 1'b0;
    checks += 6;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL reset_enable got %0b want 0", bus.enable_out); end
    if (bus.col_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %0h want 0", bus.col_tag); end
    if (bus.data_out !== 64'h0) begin errors++; $display("FAIL reset_data got %0h want 0", bus.data_out); end
    if (bus.col_mask !== 14'h0) begin errors++; $display("FAIL reset_mask got %b want 0", bus.col_mask); end
    if (bus.drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_count); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    logic [0:NC-1] exp_mask;
    exp_mask = '0; exp_mask[3] = 1'b1;
    bus.col_ready = '1;
    bus.in_valid = 1'b1; bus.in_tag = 4'd3; bus.in_data = 64'hA5;
    tick();
    bus.in_valid = 1'b0;
    checks += 4;
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL single_enable got %0b want 1", bus.enable_out); end
    if (bus.col_mask !== exp_mask) begin errors++; $display("FAIL single_mask got %b want %b", bus.col_mask, exp_mask); end
    if (bus.col_tag !== 4'd3) begin errors++; $display("FAIL single_tag got %0d want 3", bus.col_tag); end
    if (bus.data_out !== 64'hA5) begin errors++; $display("FAIL single_data got %0h want a5", bus.data_out); end
    tick();
    checks += 2;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL single_done got %0b want 0", bus.enable_out); end
    if (bus.col_tag !== 4'd3) begin errors++; $display("FAIL single_tag_hold got %0d want 3", bus.col_tag); end
  endtask

  task automatic test_backpressure();
    logic [0:NC-1] exp_mask;
    exp_mask = '0; exp_mask[5] = 1'b1;
    bus.col_ready = '0;
    bus.in_valid = 1'b1; bus.in_tag = 4'd5; bus.in_data = 64'h5555_0000_1234_5678;
    tick();
    bus.in_valid = 1'b0; bus.in_data = 64'hDEAD;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) bus.col_id[5] = 4'd7;
      if (c == 2) bus.col_ready = 14'b11111011111111;
      checks += 3;
      if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL bp_enable c%0d got %0b want 1", c, bus.enable_out); end
      if (bus.data_out !== 64'h5555_0000_1234_5678) begin errors++; $display("FAIL bp_data c%0d got %0h", c, bus.data_out); end
      if (bus.col_mask !== exp_mask) begin errors++; $display("FAIL bp_mask c%0d got %b want %b", c, bus.col_mask, exp_mask); end
      tick();
    end
    checks += 1;
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL bp_enable5 got %0b want 1", bus.enable_out); end
    bus.col_ready[5] = 1'b1;
    tick();
    checks += 1;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL bp_done got %0b want 0", bus.enable_out); end
    ids_linear();
  endtask

  task automatic test_multicast();
    logic [0:NC-1] exp_mask;
    exp_mask = '0; exp_mask[0] = 1'b1; exp_mask[1] = 1'b1;
    for (int i = 0; i < NC; i++) bus.col_id[i] = TW'(i / 2);
    bus.col_ready = '0; bus.col_ready[0] = 1'b1;
    bus.in_valid = 1'b1; bus.in_tag = 4'd0; bus.in_data = 64'h0C0C;
    tick();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.col_mask !== exp_mask) begin errors++; $display("FAIL mc_mask got %b want %b", bus.col_mask, exp_mask); end
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL mc_enable got %0b want 1", bus.enable_out); end
    tick(); tick();
    checks += 1;
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL mc_partial got %0b want 1", bus.enable_out); end
    bus.col_ready[1] = 1'b1;
    tick();
    checks += 1;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL mc_done got %0b want 0", bus.enable_out); end
    ids_linear();
  endtask

  task automatic test_back_to_back();
    bus.col_ready = '1;
    for (int b = 0; b < 6; b++) begin
      bus.in_valid = 1'b1; bus.in_tag = 4'hF; bus.in_data = 64'(100 + b);
      tick();
      checks += 3;
      if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL b2b_enable b%0d got %0b want 1", b, bus.enable_out); end
      if (bus.data_out !== 64'(100 + b)) begin errors++; $display("FAIL b2b_data b%0d got %0d want %0d", b, bus.data_out, 100 + b); end
      if (bus.col_mask !== 14'h3FFF) begin errors++; $display("FAIL b2b_mask b%0d got %b want all ones", b, bus.col_mask); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks += 1;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL b2b_done got %0b want 0", bus.enable_out); end
  endtask

  task automatic test_drop_full();
    bus.col_ready = '1;
    bus.col_id[9] = 4'd0;
    bus.in_valid = 1'b1; bus.in_tag = 4'd9; bus.in_data = 64'h99;
    tick();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL drop_enable got %0b want 0", bus.enable_out); end
    if (bus.drop_count !== 16'd1) begin errors++; $display("FAIL drop_count got %0d want 1", bus.drop_count); end
    bus.col_ready = '0;
    bus.in_valid = 1'b1; bus.in_tag = 4'd1;
    bus.in_data = 64'h11; tick();
    bus.in_data = 64'h22; tick();
    checks += 1;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %0b want 1", bus.in_ready); end
    bus.in_data = 64'h33; tick();
    bus.in_data = 64'h44;
    checks += 3;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", bus.in_ready); end
    if (bus.data_out !== 64'h11) begin errors++; $display("FAIL full_head got %0h want 11", bus.data_out); end
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL full_enable got %0b want 1", bus.enable_out); end
    tick(); tick();
    checks += 1;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_hold got %0b want 0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.col_ready = '1;
    tick();
    checks += 2;
    if (bus.data_out !== 64'h22) begin errors++; $display("FAIL full_pop1 got %0h want 22", bus.data_out); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %0b want 1", bus.in_ready); end
    tick();
    checks += 2;
    if (bus.data_out !== 64'h33) begin errors++; $display("FAIL full_pop2 got %0h want 33", bus.data_out); end
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL full_pop2_en got %0b want 1", bus.enable_out); end
    tick();
    checks += 2;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL full_drain got %0b want 0", bus.enable_out); end
    if (bus.data_out !== 64'h33) begin errors++; $display("FAIL full_no_44 got %0h want 33", bus.data_out); end
    ids_linear();
  endtask

  task automatic test_reset_mid();
    bus.col_ready = '0;
    bus.in_valid = 1'b1; bus.in_tag = 4'd2;
    bus.in_data = 64'hA1; tick();
    bus.in_data = 64'hA2; tick();
    bus.in_data = 64'hA3; tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 3;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL rst_mid_enable got %0b want 0", bus.enable_out); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b want 1", bus.in_ready); end
    if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL rst_mid_drop got %0d want 0", bus.drop_count); end
    bus.col_ready = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks += 1;
      if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL rst_stale c%0d got %0b want 0", c, bus.enable_out); end
    end
    bus.in_valid = 1'b1; bus.in_tag = 4'd2; bus.in_data = 64'hB0;
    tick();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.data_out !== 64'hB0) begin errors++; $display("FAIL rst_fresh_data got %0h want b0", bus.data_out); end
    if (bus.enable_out !== 1'b1) begin errors++; $display("FAIL rst_fresh_en got %0b want 1", bus.enable_out); end
    tick();
    checks += 1;
    if (bus.enable_out !== 1'b0) begin errors++; $display("FAIL rst_fresh_done got %0b want 0", bus.enable_out); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_multicast();
    test_back_to_back();
    test_drop_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
